// File: rtl/alu_cmd_driver.sv
// Requester front-end for the registered 4-op ALU: issues commands, tracks the
// two-edge in-flight window and buffers results in a credit-limited response FIFO.
`timescale 1ns/1ps
module alu_cmd_driver #(
   parameter int N     = 4,
   parameter int DEPTH = 4
) (
   input  logic           i_clk,
   input  logic           i_reset_n,
   input  logic           i_cmd_valid,
   output logic           o_cmd_ready,
   input  logic [1:0]     i_cmd_op,
   input  logic [N-1:0]   i_cmd_a,
   input  logic [N-1:0]   i_cmd_b,
   input  logic           i_flush,
   output logic           o_alu_reset,
   output logic [1:0]     o_alu_op_code,
   output logic [N-1:0]   o_alu_inp1,
   output logic [N-1:0]   o_alu_inp2,
   input  logic [2*N-1:0] i_alu_outp,
   output logic           o_rsp_valid,
   input  logic           i_rsp_ready,
   output logic [2*N-1:0] o_rsp_data,
   output logic [1:0]     o_rsp_op,
   output logic           o_rsp_div0,
   output logic           o_busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 2;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t         r_state, w_state_next;
   logic           r_ready_en, r_alu_reset, r_rst_hold;
   logic [1:0]     r_alu_op_code;
   logic [N-1:0]   r_alu_inp1, r_alu_inp2;
   logic           r_s1_valid, r_s1_div0, r_s2_valid, r_s2_div0;
   logic [1:0]     r_s1_op, r_s2_op;
   logic [2*N-1:0] r_mem_data [DEPTH];
   logic [1:0]     r_mem_op   [DEPTH];
   logic           r_mem_div0 [DEPTH];
   logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]  r_count;

   logic [CW-1:0]  w_outstanding;
   logic           w_accept, w_push, w_pop, w_flush_evt;

   // Credits count everything that will eventually need a FIFO slot.
   assign w_outstanding = r_count + CW'(r_s1_valid) + CW'(r_s2_valid);
   assign o_cmd_ready   = r_ready_en && (r_state == IDLE || r_state == RUN)
                          && (w_outstanding < CW'(DEPTH));
   assign w_flush_evt   = i_flush && (r_state != FLUSH);
   assign w_accept      = i_cmd_valid && o_cmd_ready && !i_flush;
   assign w_push        = r_s2_valid && (r_state != FLUSH) && !i_flush;
   assign o_rsp_valid   = (r_count != '0) && (r_state != FLUSH);
   assign w_pop         = o_rsp_valid && i_rsp_ready;

   assign o_rsp_data    = o_rsp_valid ? r_mem_data[r_rd_ptr] : '0;
   assign o_rsp_op      = o_rsp_valid ? r_mem_op[r_rd_ptr]   : 2'b00;
   assign o_rsp_div0    = o_rsp_valid ? r_mem_div0[r_rd_ptr] : 1'b0;
   assign o_alu_reset   = r_alu_reset;
   assign o_alu_op_code = r_alu_op_code;
   assign o_alu_inp1    = r_alu_inp1;
   assign o_alu_inp2    = r_alu_inp2;
   assign o_busy        = (r_state != IDLE);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = RUN;
         RUN:     if (w_outstanding == '0 && !w_accept) w_state_next = IDLE;
         FLUSH:   if (!r_s1_valid && !r_s2_valid) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
      if (w_flush_evt) w_state_next = FLUSH;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state       <= IDLE;
         r_ready_en    <= 1'b0;
         r_alu_reset   <= 1'b1;
         r_rst_hold    <= 1'b1;
         r_alu_op_code <= 2'b00;
         r_alu_inp1    <= '0;
         r_alu_inp2    <= '0;
         r_s1_valid    <= 1'b0;
         r_s1_op       <= 2'b00;
         r_s1_div0     <= 1'b0;
         r_s2_valid    <= 1'b0;
         r_s2_op       <= 2'b00;
         r_s2_div0     <= 1'b0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
      end else begin
         r_state     <= w_state_next;
         r_ready_en  <= 1'b1;
         // Stretch the ALU reset one cycle past our own reset release.
         r_alu_reset <= r_rst_hold;
         r_rst_hold  <= 1'b0;
         if (w_accept) begin
            r_alu_op_code <= i_cmd_op;
            r_alu_inp1    <= i_cmd_a;
            r_alu_inp2    <= i_cmd_b;
            r_s1_op       <= i_cmd_op;
            r_s1_div0     <= (i_cmd_op == 2'b11) && (i_cmd_b == '0);
         end
         r_s1_valid <= w_accept;
         r_s2_valid <= r_s1_valid;
         r_s2_op    <= r_s1_op;
         r_s2_div0  <= r_s1_div0;
         if (w_flush_evt) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
         end
      end
   end

   // A divide-by-zero never trusts the ALU output.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= r_s2_div0 ? '0 : i_alu_outp;
         r_mem_op[r_wr_ptr]   <= r_s2_op;
         r_mem_div0[r_wr_ptr] <= r_s2_div0;
      end
   end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Scoreboard bench for alu_cmd_driver: a behavioural ALU on the pins, expected
// results queued at command acceptance and popped by an independent monitor.
`timescale 1ns/1ps
module tb_alu_cmd_driver;
   localparam int N = 4;
   localparam int DEPTH = 4;

   logic           clk = 1'b0;
   logic           reset_n, cmd_valid, cmd_ready, flush, alu_reset;
   logic [1:0]     cmd_op, alu_op_code, rsp_op;
   logic [N-1:0]   cmd_a, cmd_b, alu_inp1, alu_inp2;
   logic [2*N-1:0] alu_outp, rsp_data;
   logic           rsp_valid, rsp_ready, rsp_div0, busy;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] op;
      logic       div0;
   } rsp_t;

   rsp_t exp_q[$];
   int   n_vec = 0;
   int   n_miss = 0;
   int   n_rsp = 0;
   bit   rand_done = 1'b0;

   always #5 clk = ~clk;

   alu_cmd_driver #(.N(N), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_reset_n(reset_n),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_op(cmd_op), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_flush(flush),
      .o_alu_reset(alu_reset), .o_alu_op_code(alu_op_code),
      .o_alu_inp1(alu_inp1), .o_alu_inp2(alu_inp2), .i_alu_outp(alu_outp),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_data(rsp_data), .o_rsp_op(rsp_op), .o_rsp_div0(rsp_div0),
      .o_busy(busy)
   );

   // Registered ALU; a divide by zero returns junk the driver must not forward.
   always @(posedge clk) begin
      if (alu_reset) alu_outp <= '0;
      else begin
         case (alu_op_code)
            2'b00: alu_outp <= {4'b0, alu_inp1} + {4'b0, alu_inp2};
            2'b01: alu_outp <= {4'b0, alu_inp1} - {4'b0, alu_inp2};
            2'b10: alu_outp <= {4'b0, alu_inp1} * {4'b0, alu_inp2};
            default: alu_outp <= (alu_inp2 == '0) ? 8'hA5 : {4'b0, alu_inp1} / {4'b0, alu_inp2};
         endcase
      end
   end

   function automatic rsp_t model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      rsp_t r;
      int   ia, ib, res;
      ia = int'(a);
      ib = int'(b);
      r.op = op;
      r.div0 = (op == 2'd3) && (ib == 0);
      case (op)
         2'd0: res = ia + ib;
         2'd1: res = ia - ib;
         2'd2: res = ia * ib;
         default: res = (ib == 0) ? 0 : ia / ib;
      endcase
      res = res & 255;
      r.data = res[7:0];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every handshake on the response port consumes one expected entry.
   always @(negedge clk) begin
      rsp_t e;
      if (rsp_valid && rsp_ready) begin
         n_rsp++;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_rsp: got data=%02h op=%0d div0=%0d, expected no response",
                     rsp_data, rsp_op, rsp_div0);
         end else begin
            e = exp_q.pop_front();
            $display("rsp %0d: data=%02h op=%0d div0=%0d", n_rsp, rsp_data, rsp_op, rsp_div0);
            check("rsp_data", 32'(rsp_data), 32'(e.data));
            check("rsp_op", 32'(rsp_op), 32'(e.op));
            check("rsp_div0", 32'(rsp_div0), 32'(e.div0));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, output int waited);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_a = a;
      cmd_b = b;
      waited = 0;
      @(negedge clk);
      while (!cmd_ready && waited < 100) begin
         waited++;
         @(negedge clk);
      end
      if (cmd_ready) begin
         exp_q.push_back(model(op, a, b));
         $display("cmd op=%0d a=%0h b=%0h waited=%0d", op, a, b, waited);
      end else begin
         n_vec++;
         n_miss++;
         $display("FAIL cmd_accept: cmd_ready stayed 0 for %0d cycles, expected 1", waited);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < 200) begin
         @(posedge clk);
         c++;
      end
      #1;
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      logic [1:0] r_op;
      logic [3:0] r_a, r_b;
      reset_n = 1'b0; cmd_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
      cmd_op = 2'b00; cmd_a = '0; cmd_b = '0;
      tick(2);
      @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_alu_pins", {alu_op_code, alu_inp1, alu_inp2}, 0);
      check("rst_rsp_fields", {rsp_data, rsp_op, rsp_div0}, 0);
      check("rst_alu_reset", 32'(alu_reset), 1);
      @(posedge clk); #1;
      reset_n = 1'b1;
      tick(1);
      @(negedge clk);
      check("alu_reset_stretch", 32'(alu_reset), 1);
      check("ready_after_reset", 32'(cmd_ready), 1);
      @(negedge clk);
      check("alu_reset_release", 32'(alu_reset), 0);
      tick(1);

      // Single ADD: pins one edge after accept, response after two more edges.
      send(2'd0, 4'h7, 4'h9, w);
      check("add_wait", 32'(w), 0);
      @(negedge clk);
      check("alu_inp1", 32'(alu_inp1), 32'h7);
      check("alu_inp2", 32'(alu_inp2), 32'h9);
      check("alu_op_code", 32'(alu_op_code), 0);
      check("latency_e1", 32'(rsp_valid), 0);
      @(negedge clk);
      check("latency_e2", 32'(rsp_valid), 0);
      @(negedge clk);
      check("latency_e3", 32'(rsp_valid), 1);
      tick(1);
      drain("drain_add");

      // Back-to-back with no stalls.
      send(2'd2, 4'hF, 4'hF, w); check("b2b_ready0", 32'(w), 0);
      send(2'd1, 4'h3, 4'h5, w); check("b2b_ready1", 32'(w), 0);
      send(2'd3, 4'hD, 4'h4, w); check("b2b_ready2", 32'(w), 0);
      send(2'd0, 4'h0, 4'h0, w); check("b2b_ready3", 32'(w), 0);
      drain("drain_b2b");

      send(2'd3, 4'h9, 4'h0, w);
      send(2'd0, 4'h1, 4'h1, w);
      drain("drain_div0");

      // Backpressure: four credits, then cmd_ready must drop.
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(2'd0, 4'(i), 4'(i + 3), w);
         check("bp_accept_wait", 32'(w), 0);
      end
      tick(3);
      @(negedge clk);
      check("bp_ready_low", 32'(cmd_ready), 0);
      check("bp_rsp_held", 32'(rsp_valid), 1);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      send(2'd2, 4'h6, 4'h7, w);
      send(2'd1, 4'h2, 4'h9, w);
      drain("drain_bp");

      // Flush one cycle after the third accept.
      send(2'd0, 4'h1, 4'h2, w);
      send(2'd2, 4'h3, 4'h4, w);
      send(2'd1, 4'h8, 4'h1, w);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      exp_q.delete();
      tick(2);
      @(negedge clk);
      check("flush_busy_clear", 32'(busy), 0);
      tick(3);
      send(2'd0, 4'h2, 4'h3, w);
      drain("drain_after_flush");

      // Reset with two operations in flight.
      send(2'd2, 4'h5, 4'h5, w);
      send(2'd0, 4'hA, 4'h3, w);
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("mid_rst_alu_reset", 32'(alu_reset), 1);
      check("mid_rst_outputs", {cmd_ready, rsp_valid, busy, rsp_data, rsp_op, rsp_div0}, 0);
      check("mid_rst_alu_pins", {alu_op_code, alu_inp1, alu_inp2}, 0);
      @(negedge clk);
      check("mid_rst_alu_reset2", 32'(alu_reset), 1);
      @(negedge clk);
      check("mid_rst_alu_reset3", 32'(alu_reset), 0);
      tick(6);

      // Randomised traffic with random response backpressure.
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               r_op = 2'($urandom_range(0, 3));
               r_a = 4'($urandom_range(0, 15));
               r_b = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
               send(r_op, r_a, r_b, w);
               if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 2));
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               rsp_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      rsp_ready = 1'b1;
      drain("drain_random");
      tick(4);
      @(negedge clk);
      check("final_idle", 32'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
